// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Purpose  : Sequencing controller for a 12-bit LED rotator. Four active-low
//            push buttons are synchronized and debounced. Each press event
//            toggles the direction, cycles the speed, selects the next pattern
//            or toggles run/pause. The controller then emits load/step pulses
//            to an external rotator register.
// Ports    : clk        - sole clock, rising edge
//            rst        - asynchronous active-high reset
//            btn_dir    - direction toggle button (active-low, async)
//            btn_speed  - speed cycle button (active-low, async)
//            btn_mode   - pattern select button (active-low, async)
//            btn_pause  - run/pause button (active-low, async)
//            load       - 1-cycle pulse, rotator takes 'pattern'
//            pattern    - 12-bit pattern selected by the pattern index
//            step       - 1-cycle pulse, rotator shifts one position
//            dir        - 0 = rotate left, 1 = rotate right
//            spd        - current speed index
//            running    - high while the sequencer is running
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BASE_PERIOD     = 2097152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_dir,
  input  logic        btn_speed,
  input  logic        btn_mode,
  input  logic        btn_pause,
  output logic        load,
  output logic [11:0] pattern,
  output logic        step,
  output logic        dir,
  output logic [1:0]  spd,
  output logic        running
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Button order: [0]=dir, [1]=speed, [2]=mode, [3]=pause
  logic [3:0] btn_raw;
  logic [3:0] press;

  assign btn_raw = {btn_pause, btn_mode, btn_speed, btn_dir};

  // --------------------------------------------------------------------------
  // Per-button synchronizer + debouncer. The counter only runs while the
  // synchronized sample disagrees with the debounced level; any agreeing
  // sample restarts it. The press event is taken from the debounced
  // next-state so the action lands on the same edge the level falls.
  // --------------------------------------------------------------------------
  for (genvar g = 0; g < 4; g++) begin : g_btn
    logic           sync1_q;
    logic           sync2_q;
    logic           deb_q;
    logic           deb_d;
    logic [DBW-1:0] cnt_q;
    logic [DBW-1:0] cnt_d;

    always_comb begin
      deb_d = deb_q;
      cnt_d = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DBW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
        deb_q   <= 1'b1;
        cnt_q   <= '0;
      end else begin
        sync1_q <= btn_raw[g];
        sync2_q <= sync1_q;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign press[g] = deb_q & ~deb_d;
  end

  // --------------------------------------------------------------------------
  // Sequencer state
  // --------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        paused_q, paused_d;
  logic [1:0]  pidx_q, pidx_d;
  logic [1:0]  spd_q, spd_d;
  logic        dir_q, dir_d;
  logic [31:0] tick_q, tick_d;
  logic        load_q, load_d;
  logic        step_q, step_d;
  logic        running_q, running_d;
  logic [31:0] period;
  logic        terminal;

  assign period   = 32'(BASE_PERIOD) << (2'd3 - spd_q);
  assign terminal = (tick_q == period - 32'd1);

  always_comb begin
    state_d   = state_q;
    paused_d  = paused_q;
    pidx_d    = pidx_q;
    spd_d     = spd_q;
    dir_d     = dir_q;
    tick_d    = tick_q;
    load_d    = 1'b0;
    step_d    = 1'b0;

    if (press[0]) dir_d    = ~dir_q;
    if (press[1]) spd_d    = spd_q + 2'd1;
    // The pause flag toggles on every pause press, even when a simultaneous
    // mode press wins the state transition; LOAD then exits into PAUSE.
    if (press[3]) paused_d = ~paused_q;

    case (state_q)
      ST_LOAD: begin
        load_d  = 1'b1;
        state_d = paused_d ? ST_PAUSE : ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (press[2]) begin
          pidx_d  = pidx_q + 2'd1;
          state_d = ST_LOAD;
        end else if (press[3]) begin
          state_d = paused_d ? ST_PAUSE : ST_RUN;
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // A speed press clears the count and suppresses a coincident step.
    if (press[1]) begin
      tick_d = '0;
    end else if (state_q == ST_LOAD) begin
      tick_d = '0;
    end else if (state_q == ST_RUN) begin
      if (terminal) begin
        tick_d = '0;
        step_d = 1'b1;
      end else begin
        tick_d = tick_q + 32'd1;
      end
    end
  end

  // The load cycle is not reported as running.
  assign running_d = (state_d == ST_RUN) & ~load_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_LOAD;
      paused_q  <= 1'b0;
      pidx_q    <= 2'd0;
      spd_q     <= 2'd0;
      dir_q     <= 1'b0;
      tick_q    <= '0;
      load_q    <= 1'b0;
      step_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      paused_q  <= paused_d;
      pidx_q    <= pidx_d;
      spd_q     <= spd_d;
      dir_q     <= dir_d;
      tick_q    <= tick_d;
      load_q    <= load_d;
      step_q    <= step_d;
      running_q <= running_d;
    end
  end

  always_comb begin
    pattern = 12'hCCD;
    case (pidx_q)
      2'd0: pattern = 12'hCCD;
      2'd1: pattern = 12'hFFE;
      2'd2: pattern = 12'hF0F;
      2'd3: pattern = 12'hAAA;
      default: pattern = 12'hCCD;
    endcase
  end

  assign load    = load_q;
  assign step    = step_q;
  assign dir     = dir_q;
  assign spd     = spd_q;
  assign running = running_q;

endmodule
`default_nettype wire
